// File: rtl/memory_cell_tuple_scanner_if.sv
// Tuple output stream of memory_cell_tuple_scanner.
//   master (scanner): drives out_valid, out_cell and the tuple fields; reads out_ready
//   slave  (consumer): reads the tuple; drives out_ready
// Handshake: a tuple transfers on a rising clk edge where out_valid && out_ready.
// While out_valid is high and out_ready is low, every field is held stable.
// out_valid never depends combinationally on out_ready.
interface memory_cell_tuple_scanner_if #(
  parameter int NUM_CELLS = 8,
  parameter int CODE_W    = 4,
  parameter int RANK_W    = 4,
  parameter int IDX_W     = 8,
  parameter int VAL_W     = 8
);
  localparam int PTR_W = $clog2(NUM_CELLS);

  logic              out_valid;
  logic              out_ready;
  logic [PTR_W-1:0]  out_cell;
  logic [CODE_W-1:0] out_array_code;
  logic              out_eltDef;
  logic [RANK_W-1:0] out_rank;
  logic [IDX_W-1:0]  out_low;
  logic [IDX_W-1:0]  out_high;
  logic [IDX_W-1:0]  out_index;
  logic [VAL_W-1:0]  out_value;
  logic              out_mark;

  modport master (
    output out_valid, out_cell, out_array_code, out_eltDef, out_rank,
           out_low, out_high, out_index, out_value, out_mark,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_cell, out_array_code, out_eltDef, out_rank,
           out_low, out_high, out_index, out_value, out_mark,
    output out_ready
  );
endinterface

// File: rtl/memory_cell_tuple_scanner.sv
// Walks a bank of memory-cell tuples one cell per cycle after a start command,
// emitting every defined cell whose handle equals the latched handle, in
// ascending cell order, on a registered valid/ready stream.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start, abort      begin scan (IDLE only) / cancel scan (SCAN or EMIT)
//   match_handle      handle searched for, latched on accepted start
//   cells_*           live per-cell fields, cell i at slice i
//   tup               tuple output stream (master side)
//   busy, done        scan in progress / one-cycle completion pulse
//   match_count       tuples handed off in current/last scan
//   dbg_state         current FSM state (IDLE=0, SCAN=1, EMIT=2, DONE=3)
module memory_cell_tuple_scanner #(
  parameter int NUM_CELLS = 8,
  parameter int HANDLE_W  = 4,
  parameter int CODE_W    = 4,
  parameter int RANK_W    = 4,
  parameter int IDX_W     = 8,
  parameter int VAL_W     = 8,
  parameter int CNT_W     = $clog2(NUM_CELLS + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [HANDLE_W-1:0]           match_handle,
  input  logic [NUM_CELLS-1:0]          cells_arrDef,
  input  logic [NUM_CELLS-1:0]          cells_eltDef,
  input  logic [NUM_CELLS-1:0]          cells_mark,
  input  logic [NUM_CELLS*HANDLE_W-1:0] cells_handle,
  input  logic [NUM_CELLS*CODE_W-1:0]   cells_array_code,
  input  logic [NUM_CELLS*RANK_W-1:0]   cells_rank,
  input  logic [NUM_CELLS*IDX_W-1:0]    cells_low,
  input  logic [NUM_CELLS*IDX_W-1:0]    cells_high,
  input  logic [NUM_CELLS*IDX_W-1:0]    cells_index,
  input  logic [NUM_CELLS*VAL_W-1:0]    cells_value,
  memory_cell_tuple_scanner_if.master   tup,
  output logic                          busy,
  output logic                          done,
  output logic [CNT_W-1:0]              match_count,
  output logic [1:0]                    dbg_state
);
  localparam int PTR_W = $clog2(NUM_CELLS);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_CELLS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, EMIT = 2'd2, DONE = 2'd3} state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [HANDLE_W-1:0] handle_q, handle_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                valid_q, valid_d;
  logic                load;

  logic [PTR_W-1:0]    cell_q;
  logic [CODE_W-1:0]   code_q;
  logic                elt_q;
  logic [RANK_W-1:0]   rank_q;
  logic [IDX_W-1:0]    low_q, high_q, index_q;
  logic [VAL_W-1:0]    value_q;
  logic                mark_q;

  // Unpacked views of the flat bank so the live cell can be picked by ptr.
  logic [HANDLE_W-1:0] handle_a [NUM_CELLS];
  logic [CODE_W-1:0]   code_a   [NUM_CELLS];
  logic [RANK_W-1:0]   rank_a   [NUM_CELLS];
  logic [IDX_W-1:0]    low_a    [NUM_CELLS];
  logic [IDX_W-1:0]    high_a   [NUM_CELLS];
  logic [IDX_W-1:0]    index_a  [NUM_CELLS];
  logic [VAL_W-1:0]    value_a  [NUM_CELLS];

  for (genvar i = 0; i < NUM_CELLS; i++) begin : g_unpack
    assign handle_a[i] = cells_handle[i*HANDLE_W +: HANDLE_W];
    assign code_a[i]   = cells_array_code[i*CODE_W +: CODE_W];
    assign rank_a[i]   = cells_rank[i*RANK_W +: RANK_W];
    assign low_a[i]    = cells_low[i*IDX_W +: IDX_W];
    assign high_a[i]   = cells_high[i*IDX_W +: IDX_W];
    assign index_a[i]  = cells_index[i*IDX_W +: IDX_W];
    assign value_a[i]  = cells_value[i*VAL_W +: VAL_W];
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    handle_d = handle_q;
    count_d  = count_q;
    valid_d  = valid_q;
    load     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          handle_d = match_handle;
          ptr_d    = '0;
          count_d  = '0;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cells_arrDef[ptr_q] && (handle_a[ptr_q] == handle_q)) begin
          load    = 1'b1;
          valid_d = 1'b1;
          state_d = EMIT;
        end else if (ptr_q == LAST) begin
          state_d = DONE;
        end else begin
          ptr_d = ptr_q + PTR_W'(1);
        end
      end
      EMIT: begin
        if (valid_q && tup.out_ready) begin
          valid_d = 1'b0;
          count_d = count_q + CNT_W'(1);
          if (ptr_q == LAST) begin
            state_d = DONE;
          end else begin
            ptr_d   = ptr_q + PTR_W'(1);
            state_d = SCAN;
          end
        end
        // Abort wins the state, but a coincident handshake has already been counted.
        if (abort) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      handle_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      cell_q   <= '0;
      code_q   <= '0;
      elt_q    <= 1'b0;
      rank_q   <= '0;
      low_q    <= '0;
      high_q   <= '0;
      index_q  <= '0;
      value_q  <= '0;
      mark_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      handle_q <= handle_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      // Fields are only loaded on a match, so they keep the last tuple after handoff.
      if (load) begin
        cell_q  <= ptr_q;
        code_q  <= code_a[ptr_q];
        elt_q   <= cells_eltDef[ptr_q];
        rank_q  <= rank_a[ptr_q];
        low_q   <= low_a[ptr_q];
        high_q  <= high_a[ptr_q];
        index_q <= index_a[ptr_q];
        value_q <= value_a[ptr_q];
        mark_q  <= cells_mark[ptr_q];
      end
    end
  end

  assign tup.out_valid      = valid_q;
  assign tup.out_cell       = cell_q;
  assign tup.out_array_code = code_q;
  assign tup.out_eltDef     = elt_q;
  assign tup.out_rank       = rank_q;
  assign tup.out_low        = low_q;
  assign tup.out_high       = high_q;
  assign tup.out_index      = index_q;
  assign tup.out_value      = value_q;
  assign tup.out_mark       = mark_q;

  assign busy        = (state_q == SCAN) || (state_q == EMIT);
  assign done        = (state_q == DONE);
  assign match_count = count_q;
  assign dbg_state   = state_q;
endmodule

// File: tb/tb_memory_cell_tuple_scanner.sv
// Self-checking bench for memory_cell_tuple_scanner: table of scan scenarios,
// hand-written reset/abort/restart sequences, and randomized banks checked
// against a reference model of which cells should be emitted and when.
module tb_memory_cell_tuple_scanner;
  localparam int NC = 8;
  localparam int HW = 4;
  localparam int TW = 3 + 4 + 1 + 4 + 8 + 8 + 8 + 8 + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b0;
  logic [HW-1:0] match_handle = '0;

  logic [NC-1:0] bank_arr = '0, bank_elt = '0, bank_mark = '0;
  logic [3:0]    bank_handle [NC];
  logic [3:0]    bank_code   [NC];
  logic [3:0]    bank_rank   [NC];
  logic [7:0]    bank_low    [NC];
  logic [7:0]    bank_high   [NC];
  logic [7:0]    bank_index  [NC];
  logic [7:0]    bank_value  [NC];

  logic [NC*4-1:0] cells_handle, cells_array_code, cells_rank;
  logic [NC*8-1:0] cells_low, cells_high, cells_index, cells_value;

  always_comb begin
    for (int i = 0; i < NC; i++) begin
      cells_handle[i*4 +: 4]     = bank_handle[i];
      cells_array_code[i*4 +: 4] = bank_code[i];
      cells_rank[i*4 +: 4]       = bank_rank[i];
      cells_low[i*8 +: 8]        = bank_low[i];
      cells_high[i*8 +: 8]       = bank_high[i];
      cells_index[i*8 +: 8]      = bank_index[i];
      cells_value[i*8 +: 8]      = bank_value[i];
    end
  end

  logic       busy, done;
  logic [3:0] match_count;
  logic [1:0] dbg_state;

  memory_cell_tuple_scanner_if #(.NUM_CELLS(NC)) tup ();
  assign tup.out_ready = out_ready;

  memory_cell_tuple_scanner #(.NUM_CELLS(NC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .match_handle(match_handle),
    .cells_arrDef(bank_arr), .cells_eltDef(bank_elt), .cells_mark(bank_mark),
    .cells_handle(cells_handle), .cells_array_code(cells_array_code),
    .cells_rank(cells_rank), .cells_low(cells_low), .cells_high(cells_high),
    .cells_index(cells_index), .cells_value(cells_value),
    .tup(tup), .busy(busy), .done(done), .match_count(match_count),
    .dbg_state(dbg_state)
  );

  // scoreboard
  int checks = 0;
  int failures = 0;
  logic [TW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [TW-1:0] exp_tuple(input int c);
    return {3'(c), bank_code[c], bank_elt[c], bank_rank[c], bank_low[c],
            bank_high[c], bank_index[c], bank_value[c], bank_mark[c]};
  endfunction

  function automatic logic [TW-1:0] obs_tuple();
    return {tup.out_cell, tup.out_array_code, tup.out_eltDef, tup.out_rank, tup.out_low,
            tup.out_high, tup.out_index, tup.out_value, tup.out_mark};
  endfunction

  // driver tasks
  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic rand_fields();
    for (int i = 0; i < NC; i++) begin
      bank_code[i]  = 4'($urandom);
      bank_rank[i]  = 4'($urandom);
      bank_low[i]   = 8'($urandom);
      bank_high[i]  = 8'($urandom);
      bank_index[i] = 8'($urandom);
      bank_value[i] = 8'($urandom);
    end
    bank_elt  = 8'($urandom);
    bank_mark = 8'($urandom);
  endtask

  // Reference model: emitted cells are the defined cells with the requested handle,
  // ascending. Cell c is examined after every earlier cell (1 cycle each) and every
  // earlier emission (1 cycle plus its stalls), so its tuple appears at
  // c + 2 + handshakes + stalls so far; done lands at NC + 1 + matches + stalls.
  task automatic run_scan(input logic [HW-1:0] hnd, input int stall_first, input bit rnd_ready,
                          input int restart_at, output int done_cyc, output int hs_cnt);
    int cyc, stalls, stall_left, nm, bad_busy;
    int vcells[$];
    bit prev_valid;
    exp_q.delete();
    for (int c = 0; c < NC; c++) begin
      if (bank_arr[c] && bank_handle[c] == hnd) begin
        exp_q.push_back(exp_tuple(c));
        vcells.push_back(c);
      end
    end
    nm = exp_q.size();
    match_handle = hnd;
    start = 1'b1;
    out_ready = 1'b1;
    step();
    start = 1'b0;
    match_handle = ~hnd;  // the scan must use the latched handle
    cyc = 1; done_cyc = -1; hs_cnt = 0; stalls = 0; stall_left = stall_first;
    prev_valid = 1'b0; bad_busy = 0;
    while (cyc < 200) begin
      if (tup.out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", 64'(tup.out_valid), 64'(0));
        end else begin
          if (!prev_valid) check("valid_cycle", 64'(cyc), 64'(vcells[0] + 2 + hs_cnt + stalls));
          check("tuple", 64'(obs_tuple()), 64'(exp_q[0]));
        end
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (busy !== 1'b1) bad_busy++;
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
      else out_ready = !(tup.out_valid && stall_left > 0);
      if (tup.out_valid) begin
        if (out_ready) begin
          if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            void'(vcells.pop_front());
          end
          hs_cnt++;
        end else begin
          stalls++;
          if (stall_left > 0) stall_left--;
        end
      end
      prev_valid = tup.out_valid && !out_ready;
      start = (cyc == restart_at);
      if (start) match_handle = hnd + 4'd1;
      step();
      start = 1'b0;
      cyc++;
    end
    if (done_cyc < 0) begin
      check("done_timeout", 64'(cyc), 64'(NC + 1 + nm + stalls));
      do_reset();
    end else begin
      check("done_cycle", 64'(done_cyc), 64'(NC + 1 + nm + stalls));
      check("match_count", 64'(match_count), 64'(nm));
      check("busy_during_scan", 64'(bad_busy), 64'(0));
      check("busy_at_done", 64'(busy), 64'(0));
      check("queue_drained", 64'(exp_q.size()), 64'(0));
      step();
      check("done_one_cycle", 64'({done, busy}), 64'(0));
    end
  endtask

  typedef struct {
    logic [7:0]  arr_def;
    logic [31:0] handles;
    logic [3:0]  hnd;
    int          stall;
    int          exp_count;
    int          exp_done;
  } vec_t;

  vec_t vecs [7];

  task automatic load_vec(input vec_t v);
    bank_arr = v.arr_def;
    for (int i = 0; i < NC; i++) bank_handle[i] = v.handles[i*4 +: 4];
    rand_fields();
  endtask

  initial begin
    int dc, hs, cyc;

    vecs[0] = '{8'hFF, 32'h1111_1111, 4'd3, 0, 0, 9};   // no match
    vecs[1] = '{8'hFF, 32'h1131_1311, 4'd3, 0, 2, 11};  // cells 2 and 5
    vecs[2] = '{8'hFF, 32'h1131_1311, 4'd3, 4, 2, 15};  // first match stalls 4 valid cycles
    vecs[3] = '{8'hFD, 32'h3000_0030, 4'd3, 0, 1, 10};  // cell 1 undefined, cell 7 last
    vecs[4] = '{8'hFF, 32'h3333_3333, 4'd3, 0, 8, 17};  // every cell
    vecs[5] = '{8'h00, 32'h3333_3333, 4'd3, 0, 0, 9};   // handles match, nothing defined
    vecs[6] = '{8'hFF, 32'h3222_2223, 4'd3, 0, 2, 11};  // first and last cell

    load_vec(vecs[0]);
    do_reset();
    check("rst_valid", 64'(tup.out_valid), 64'(0));
    check("rst_busy_done", 64'({busy, done}), 64'(0));
    check("rst_count", 64'(match_count), 64'(0));
    check("rst_fields", 64'(obs_tuple()), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(0));

    foreach (vecs[k]) begin
      load_vec(vecs[k]);
      run_scan(vecs[k].hnd, vecs[k].stall, 1'b0, -1, dc, hs);
      check("tbl_done_cycle", 64'(dc), 64'(vecs[k].exp_done));
      check("tbl_count", 64'(hs), 64'(vecs[k].exp_count));
    end

    // start pulsed while busy is ignored
    load_vec(vecs[1]);
    run_scan(4'd3, 0, 1'b0, 3, dc, hs);
    check("restart_done_cycle", 64'(dc), 64'(11));
    check("restart_count", 64'(hs), 64'(2));

    // reset while a tuple is pending in EMIT
    load_vec(vecs[1]);
    match_handle = 4'd3; out_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    while (!tup.out_valid && cyc < 20) begin step(); cyc++; end
    check("emit_reached", 64'(tup.out_valid), 64'(1));
    rst_n = 1'b0;
    step();
    check("midrst_valid", 64'(tup.out_valid), 64'(0));
    check("midrst_outputs", 64'({busy, done, match_count}), 64'(0));
    check("midrst_fields", 64'(obs_tuple()), 64'(0));
    rst_n = 1'b1;
    step();
    check("midrst_idle", 64'({busy, done, dbg_state}), 64'(0));

    // abort during EMIT with out_ready low: first tuple handed off, second abandoned
    load_vec(vecs[1]);
    match_handle = 4'd3; out_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    hs = 0; cyc = 0;
    while (cyc < 30) begin
      if (tup.out_valid) begin
        if (hs == 0) hs++;
        else begin
          out_ready = 1'b0;
          abort = 1'b1;
          break;
        end
      end
      step();
      cyc++;
    end
    check("abort_reached_second", 64'(hs), 64'(1));
    step();
    abort = 1'b0;
    check("abort_valid", 64'(tup.out_valid), 64'(0));
    check("abort_busy_done", 64'({busy, done}), 64'(0));
    check("abort_count", 64'(match_count), 64'(1));
    step();
    check("abort_no_done", 64'({busy, done}), 64'(0));

    // randomized banks and back-pressure
    for (int r = 0; r < 25; r++) begin
      bank_arr = 8'($urandom);
      for (int i = 0; i < NC; i++) bank_handle[i] = 4'($urandom_range(0, 3));
      rand_fields();
      run_scan(4'($urandom_range(0, 3)), 0, 1'b1, (r % 3 == 0) ? 5 : -1, dc, hs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
